// File: rtl/ram_burst_ctrl.sv
// Word RAM behind a valid/ready request port. It serves single-word writes and
// incrementing read bursts, and the read beats stop while the consumer stalls.
module ram_burst_ctrl #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 4,
    parameter logic [DATA_W*(2**ADDR_W)-1:0] INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {IDLE, READ} state_t;

    // Word i sits at mem[i], so the flat power-up image maps onto the array directly.
    // Reset leaves the contents alone.
    logic [DEPTH-1:0][DATA_W-1:0] mem = INIT;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  left;
    logic              slot_free;
    logic              accept;

    // Both ports use valid/ready. A transfer happens at a rising edge where valid
    // and ready are both high. Valid holds until the transfer. Ready may not wait
    // on valid, and data is stable while valid is high.
    assign slot_free = !rsp_valid || rsp_ready;
    assign req_ready = (state == IDLE) && slot_free;
    assign accept    = req_valid && req_ready;
    assign busy      = (state == READ);

    always_ff @(posedge clk) begin
        if (accept && req_we) begin
            mem[req_addr] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
            cur_addr  <= '0;
            left      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !req_we) begin
                        rsp_data  <= mem[req_addr];
                        rsp_valid <= 1'b1;
                        rsp_last  <= (req_len == '0);
                        if (req_len != '0) begin
                            cur_addr <= req_addr + 1'b1;
                            left     <= req_len - 1'b1;
                            state    <= READ;
                        end
                    end else if (accept) begin
                        // A write leaves rsp_last as it was. A beat taken at this edge still retires.
                        if (rsp_ready) begin
                            rsp_valid <= 1'b0;
                        end
                    end else if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                    end
                end
                READ: begin
                    if (slot_free) begin
                        rsp_data  <= mem[cur_addr];
                        rsp_valid <= 1'b1;
                        rsp_last  <= (left == '0);
                        cur_addr  <= cur_addr + 1'b1;
                        left      <= left - 1'b1;
                        if (left == '0) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl. It covers reset, write/read, wrapping
// bursts, back-pressure, reset in the middle of a burst and the longest burst.
module tb_ram_burst_ctrl;
    localparam int DATA_W = 20;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 4;
    localparam int DEPTH  = 1024;

    function automatic logic [DATA_W*DEPTH-1:0] make_init();
        logic [DATA_W*DEPTH-1:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[DATA_W*i +: DATA_W] = DATA_W'(32'h100 + i);
        r[DATA_W*5 +: DATA_W] = 20'h12345;
        return r;
    endfunction

    localparam logic [DATA_W*DEPTH-1:0] INIT_IMG = make_init();

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              busy;

    logic [DATA_W-1:0] model [DEPTH];
    int n_checks = 0;
    int n_errors = 0;

    ram_burst_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .INIT(INIT_IMG)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        check("wr_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0; req_we = 1'b0;
        model[a] = d;
    endtask

    // Each beat is checked against the model. The bench can hold one beat
    // (stall_beat) for stall_n cycles.
    task automatic read_burst(input logic [ADDR_W-1:0] a, input int len,
                              input int stall_beat, input int stall_n);
        logic [ADDR_W-1:0] ba;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = LEN_W'(len);
        rsp_ready = 1'b1;
        check("rd_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            ba = a + ADDR_W'(b);
            check("beat_valid", 32'(rsp_valid), 32'd1);
            check("beat_data", 32'(rsp_data), 32'(model[ba]));
            check("beat_last", 32'(rsp_last), 32'(b == len));
            check("beat_busy", 32'(busy), 32'(b < len));
            if (b == stall_beat) begin
                rsp_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    check("stall_valid", 32'(rsp_valid), 32'd1);
                    check("stall_data", 32'(rsp_data), 32'(model[ba]));
                    check("stall_last", 32'(rsp_last), 32'(b == len));
                    check("stall_req_ready", 32'(req_ready), 32'd0);
                end
                rsp_ready = 1'b1;
            end
            tick();
        end
        check("burst_drained", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = INIT_IMG[DATA_W*i +: DATA_W];
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_len = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_data", 32'(rsp_data), 32'd0);
        check("rst_last", 32'(rsp_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // 1: single read of the INIT word, then an async reset while the beat is held
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd5; req_len = 4'd0;
        tick();
        req_valid = 1'b0;
        check("t1_valid", 32'(rsp_valid), 32'd1);
        check("t1_data", 32'(rsp_data), 32'h12345);
        check("t1_last", 32'(rsp_last), 32'd1);
        rsp_ready = 1'b0;
        tick();
        check("t1_hold", 32'(rsp_data), 32'h12345);
        #3 rst_n = 1'b0;
        #1;
        check("t1_async_valid", 32'(rsp_valid), 32'd0);
        check("t1_async_data", 32'(rsp_data), 32'd0);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();

        // 2: write, then read the same address back-to-back
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd7; req_wdata = 20'hABCDE;
        check("t2_wr_ready", 32'(req_ready), 32'd1);
        tick();
        model[7] = 20'hABCDE;
        req_we = 1'b0; req_len = 4'd0;
        check("t2_rd_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("t2_valid", 32'(rsp_valid), 32'd1);
        check("t2_data", 32'(rsp_data), 32'hABCDE);
        check("t2_last", 32'(rsp_last), 32'd1);
        tick();
        check("t2_drained", 32'(rsp_valid), 32'd0);

        // 3: burst that wraps from address 1023 to 0
        do_write(10'd1022, 20'd1);
        do_write(10'd1023, 20'd2);
        do_write(10'd0, 20'd3);
        do_write(10'd1, 20'd4);
        read_burst(10'd1022, 3, -1, 0);

        // 4: same burst with beat 2 held for three cycles
        read_burst(10'd1022, 3, 1, 3);

        // 5: reset after three beats of an 8-beat burst
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd16; req_len = 4'd7;
        tick();
        req_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            check("t5_data", 32'(rsp_data), 32'(model[16+b]));
            tick();
        end
        check("t5_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(rsp_valid), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t5_no_stale", 32'(rsp_valid), 32'd0);
            check("t5_req_ready", 32'(req_ready), 32'd1);
            tick();
        end
        read_burst(10'd20, 0, -1, 0);
        check("t5_mem_kept", 32'(model[20]), 32'h114);

        // 6: 16-beat burst while a write waits at the request port
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd0; req_len = 4'hF;
        tick();
        req_we = 1'b1; req_addr = 10'd30; req_wdata = 20'h5A5A5;
        for (int b = 0; b < 16; b++) begin
            check("t6_data", 32'(rsp_data), 32'(model[b]));
            check("t6_last", 32'(rsp_last), 32'(b == 15));
            check("t6_req_ready", 32'(req_ready), 32'(b == 15));
            tick();
        end
        req_valid = 1'b0; req_we = 1'b0;
        model[30] = 20'h5A5A5;
        check("t6_drained", 32'(rsp_valid), 32'd0);
        read_burst(10'd30, 0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
- Parametrised successor to the team's single-port combinational-read RAM.
- Adds configurable width and depth, a registered synchronous read port, and a valid/ready request handshake.
- Adds multi-beat incrementing read bursts with response back-pressure.
- Sits between the CPU memory stage (or a future fetch/DMA unit) and the word storage, replacing the direct ld/str strobes.

Parameters:
DATA_W, 20, word width in bits
ADDR_W, 10, address width; DEPTH = 2**ADDR_W words (localparam)
LEN_W, 4, burst length field width; max burst = 2**LEN_W beats
INIT, {DEPTH{DATA_W'd0}}, flat power-up image, DATA_W*DEPTH bits; word i = INIT[(DATA_W*i) +: DATA_W]

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready at a rising edge
req_we  input  1  1 = single-word write, 0 = read burst
req_addr  input  ADDR_W  start address
req_len  input  LEN_W  read beats minus 1 (ignored for writes)
req_wdata  input  DATA_W  write data
rsp_valid  output  1  rsp_data holds a read beat
rsp_ready  input  1  consumer takes beat when rsp_valid && rsp_ready
rsp_data  output  DATA_W  read data, registered
rsp_last  output  1  final beat of the current burst
busy  output  1  burst in progress (state READ)

Behaviour:
- Storage: DEPTH x DATA_W array, loaded from INIT at time 0 only.
  - Reset never clears storage.
- Reset (async, rst_n=0):
  - state=IDLE; rsp_valid=0, rsp_last=0, rsp_data=0, busy=0.
  - Internal address/beat counters cleared.
  - A burst in flight is abandoned and no further beats are emitted.
- Definition: slot_free = !rsp_valid || rsp_ready.
- req_ready = (state==IDLE) && slot_free, combinational.
  - Writes and reads are strictly ordered behind any undelivered beat.
- IDLE, write accepted:
  - mem[req_addr] <= req_wdata at the accepting edge.
  - State stays IDLE; back-to-back writes are possible every cycle.
  - The rsp_* registers keep their values, except that rsp_valid drops to 0 if the pending beat is consumed that edge.
- IDLE, read accepted:
  - Same edge: rsp_data <= mem[req_addr], rsp_valid <= 1, rsp_last <= (req_len==0).
  - Latency: data is valid the cycle after acceptance.
  - If req_len != 0: cur_addr <= req_addr+1, left <= req_len-1, state -> READ.
- READ state:
  - Each edge with slot_free: rsp_data <= mem[cur_addr], rsp_valid <= 1, rsp_last <= (left==0), cur_addr increments, left decrements.
  - When the beat issued has left==0, state -> IDLE.
- No accept or issue, beat consumed: rsp_valid <= 0, rsp_last <= 0.
- Stall (rsp_valid && !rsp_ready): rsp_data and rsp_last are held stable; no issue occurs and counters are frozen.
- Throughput: with rsp_ready tied high, an N-beat burst returns N beats on N consecutive cycles.
  - A new request is accepted in the same cycle the last beat is consumed.
- Wrap-around: cur_addr increments modulo DEPTH, so address DEPTH-1 is followed by address 0.
- Burst length: req_len = 2**LEN_W-1 yields 2**LEN_W beats. Longer bursts are not expressible.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- busy = (state==READ). It is low while only the final beat awaits consumption.

Test Plan:
1. Reset/init: INIT word 5 = 20'h12345, rst_n pulsed low mid-cycle -> rsp_valid=0, rsp_data=0 immediately; single read of addr 5 -> rsp_valid the next cycle, rsp_data=20'h12345, rsp_last=1.
2. Write then read: write 20'hABCDE to addr 7, read addr 7 the next cycle (len 0) -> rsp_data=20'hABCDE one cycle later; req_ready stays 1 across both accepts.
3. Burst with wrap: mem[1022..1023,0..1] = 1,2,3,4; read addr 1022, len 3, rsp_ready=1 -> beats 1,2,3,4 on four consecutive cycles, rsp_last only on beat 4; busy high for 3 cycles.
4. Back-pressure: same burst with rsp_ready low for 3 cycles on beat 2 -> rsp_data=2 held, req_ready=0, no beat lost or duplicated, remaining order 3,4 intact.
5. Reset mid-burst: 8-beat read, rst_n low after beat 3 -> rsp_valid=0 at once; after release, state IDLE, req_ready=1, no stale beats; memory contents unchanged.
6. Max length: req_len=4'hF from addr 0 -> exactly 16 beats (addr 0..15), rsp_last on the 16th; a write offered during the burst is accepted only in the cycle the 16th beat is consumed.
